// File: rtl/guvm_feeder_pkg.sv
// Shared definitions for the instruction feeder slice.
// Contents: default instruction width, the NOP returned on underflow,
// and the instruction word type.
package guvm_feeder_pkg;

   localparam int unsigned INSTR_RDATA_WIDTH = 32;

   // addi x0,x0,0
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef logic [INSTR_RDATA_WIDTH-1:0] instr_t;

endpackage

// File: rtl/guvm_sync_fifo.sv
// Synchronous FIFO holding driver-supplied instructions.
// Ports:
//   clk_i   in  1      clock
//   rst_i   in  1      asynchronous active-high reset (empties the FIFO)
//   push_i  in  1      write data_i (ignored when full)
//   data_i  in  W      entry to write
//   pop_i   in  1      drop head entry (ignored when empty)
//   full_o  out 1      no free entry
//   empty_o out 1      no valid entry
//   head_o  out W      oldest entry
module guvm_sync_fifo
   import guvm_feeder_pkg::*;
#(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   // One extra MSB on each pointer distinguishes full from empty.
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic         w_do_push;
   logic         w_do_pop;

   assign empty_o   = (r_wr_ptr == r_rd_ptr);
   assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_push = push_i & ~full_o;
   assign w_do_pop  = pop_i & ~empty_o;
   assign head_o    = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/guvm_instr_feeder.sv
// Instruction-memory responder for a core fetch port. The driver loads a
// program into a FIFO; every granted fetch is answered RVALID_LATENCY
// cycles later with the next FIFO entry, in grant order. An answer that
// finds the FIFO empty returns NOP and sets a sticky underflow flag.
// Ports:
//   clk_i          in  1   clock
//   rst_i          in  1   asynchronous active-high reset
//   instr_req_i    in  1   fetch request
//   instr_addr_i   in  32  fetch address (recorded only, not used for data)
//   instr_gnt_o    out 1   request accepted this cycle (combinational)
//   instr_rvalid_o out 1   instr_rdata_o valid this cycle
//   instr_rdata_o  out W   returned instruction, holds when rvalid low
//   ld_valid_i     in  1   driver push
//   ld_instr_i     in  W   instruction to push
//   ld_ready_o     out 1   FIFO not full
//   last_addr_o    out 32  address of most recent granted request
//   fetch_cnt_o    out 32  rvalid beats since reset
//   underflow_o    out 1   sticky: a beat found the FIFO empty
module guvm_instr_feeder
   import guvm_feeder_pkg::*;
#(
   parameter int unsigned INSTR_RDATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH        = 16,
   parameter int unsigned RVALID_LATENCY    = 1,
   parameter int unsigned MAX_OUTSTANDING   = 2,
   parameter logic [INSTR_RDATA_WIDTH-1:0] NOP_INSTR =
      INSTR_RDATA_WIDTH'(guvm_feeder_pkg::NOP_INSTR)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         instr_req_i,
   input  logic [31:0]                  instr_addr_i,
   output logic                         instr_gnt_o,
   output logic                         instr_rvalid_o,
   output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_o,
   input  logic                         ld_valid_i,
   input  logic [INSTR_RDATA_WIDTH-1:0] ld_instr_i,
   output logic                         ld_ready_o,
   output logic [31:0]                  last_addr_o,
   output logic [31:0]                  fetch_cnt_o,
   output logic                         underflow_o
);

   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

   logic [RVALID_LATENCY-1:0]    r_pipe;
   logic [RVALID_LATENCY-1:0]    w_next;
   logic [OW-1:0]                r_outstanding;
   logic [INSTR_RDATA_WIDTH-1:0] r_rdata;
   logic [31:0]                  r_last_addr;
   logic [31:0]                  r_fetch_cnt;
   logic                         r_underflow;
   logic                         w_gnt;
   logic                         w_ret;
   logic                         w_full;
   logic                         w_empty;
   logic [INSTR_RDATA_WIDTH-1:0] w_head;

   assign w_gnt = instr_req_i & (r_outstanding < OW'(MAX_OUTSTANDING));

   // The top stage of r_pipe is the registered rvalid itself, so a token
   // entering the top stage is the beat being answered at this edge.
   if (RVALID_LATENCY == 1) begin : g_lat1
      assign w_next = w_gnt;
   end else begin : g_latn
      assign w_next = {r_pipe[RVALID_LATENCY-2:0], w_gnt};
   end

   assign w_ret = w_next[RVALID_LATENCY-1];

   guvm_sync_fifo #(
      .W     (INSTR_RDATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (ld_valid_i),
      .data_i  (ld_instr_i),
      .pop_i   (w_ret),
      .full_o  (w_full),
      .empty_o (w_empty),
      .head_o  (w_head)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pipe        <= '0;
         r_outstanding <= '0;
         r_rdata       <= '0;
         r_last_addr   <= '0;
         r_fetch_cnt   <= '0;
         r_underflow   <= 1'b0;
      end else begin
         r_pipe <= w_next;
         if (w_gnt) r_last_addr <= instr_addr_i;
         case ({w_gnt, w_ret})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
         if (w_ret) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_empty) begin
               r_rdata     <= NOP_INSTR;
               r_underflow <= 1'b1;
            end else begin
               r_rdata <= w_head;
            end
         end
      end
   end

   assign instr_gnt_o    = w_gnt;
   assign instr_rvalid_o = r_pipe[RVALID_LATENCY-1];
   assign instr_rdata_o  = r_rdata;
   assign ld_ready_o     = ~w_full;
   assign last_addr_o    = r_last_addr;
   assign fetch_cnt_o    = r_fetch_cnt;
   assign underflow_o    = r_underflow;

endmodule

// File: tb/tb_guvm_instr_feeder.sv
// Directed bench for guvm_instr_feeder: instance A uses latency 1,
// instance B uses latency 3; both allow two outstanding fetches.
module tb_guvm_instr_feeder;
   import guvm_feeder_pkg::*;

   localparam logic [31:0] NOP = 32'h00000013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_req, a_gnt, a_rvalid, a_ld_valid, a_ld_ready, a_underflow;
   logic [31:0] a_addr, a_last_addr, a_fetch_cnt;
   instr_t      a_rdata, a_ld_instr;
   logic        b_rst, b_req, b_gnt, b_rvalid, b_ld_valid, b_ld_ready, b_underflow;
   logic [31:0] b_addr, b_last_addr, b_fetch_cnt;
   instr_t      b_rdata, b_ld_instr;

   int n_checks = 0;
   int n_fail   = 0;

   guvm_instr_feeder #(
      .INSTR_RDATA_WIDTH (32),
      .FIFO_DEPTH        (16),
      .RVALID_LATENCY    (1),
      .MAX_OUTSTANDING   (2)
   ) u_dut_a (
      .clk_i (clk), .rst_i (a_rst), .instr_req_i (a_req), .instr_addr_i (a_addr),
      .instr_gnt_o (a_gnt), .instr_rvalid_o (a_rvalid), .instr_rdata_o (a_rdata),
      .ld_valid_i (a_ld_valid), .ld_instr_i (a_ld_instr), .ld_ready_o (a_ld_ready),
      .last_addr_o (a_last_addr), .fetch_cnt_o (a_fetch_cnt), .underflow_o (a_underflow)
   );

   guvm_instr_feeder #(
      .INSTR_RDATA_WIDTH (32),
      .FIFO_DEPTH        (16),
      .RVALID_LATENCY    (3),
      .MAX_OUTSTANDING   (2)
   ) u_dut_b (
      .clk_i (clk), .rst_i (b_rst), .instr_req_i (b_req), .instr_addr_i (b_addr),
      .instr_gnt_o (b_gnt), .instr_rvalid_o (b_rvalid), .instr_rdata_o (b_rdata),
      .ld_valid_i (b_ld_valid), .ld_instr_i (b_ld_instr), .ld_ready_o (b_ld_ready),
      .last_addr_o (b_last_addr), .fetch_cnt_o (b_fetch_cnt), .underflow_o (b_underflow)
   );

   task automatic reset_a();
      @(negedge clk);
      a_rst = 1'b1; a_req = 1'b0; a_ld_valid = 1'b0;
      @(negedge clk);
      a_rst = 1'b0;
   endtask

   task automatic reset_b();
      @(negedge clk);
      b_rst = 1'b1; b_req = 1'b0; b_ld_valid = 1'b0;
      @(negedge clk);
      b_rst = 1'b0;
   endtask

   task automatic push_a(input logic [31:0] v);
      @(negedge clk);
      a_ld_valid = 1'b1; a_ld_instr = v;
      @(negedge clk);
      a_ld_valid = 1'b0;
   endtask

   task automatic push_b(input logic [31:0] v);
      @(negedge clk);
      b_ld_valid = 1'b1; b_ld_instr = v;
      @(negedge clk);
      b_ld_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      a_rst = 1'b1; b_rst = 1'b1;
      a_req = 1'b0; b_req = 1'b0; a_ld_valid = 1'b0; b_ld_valid = 1'b0;
      @(negedge clk);
      if (a_gnt !== 1'b0) begin $display("FAIL rst_gnt: got %b exp 0", a_gnt); n_fail++; end
      n_checks++;
      if (a_rvalid !== 1'b0) begin $display("FAIL rst_rvalid: got %b exp 0", a_rvalid); n_fail++; end
      n_checks++;
      if (a_rdata !== 32'h0) begin $display("FAIL rst_rdata: got %h exp 0", a_rdata); n_fail++; end
      n_checks++;
      if (a_last_addr !== 32'h0) begin $display("FAIL rst_last_addr: got %h exp 0", a_last_addr); n_fail++; end
      n_checks++;
      if (a_fetch_cnt !== 32'h0) begin $display("FAIL rst_fetch_cnt: got %0d exp 0", a_fetch_cnt); n_fail++; end
      n_checks++;
      if (a_underflow !== 1'b0) begin $display("FAIL rst_underflow: got %b exp 0", a_underflow); n_fail++; end
      n_checks++;
      if (a_ld_ready !== 1'b1) begin $display("FAIL rst_ld_ready: got %b exp 1", a_ld_ready); n_fail++; end
      n_checks++;
      if (b_ld_ready !== 1'b1) begin $display("FAIL rst_b_ld_ready: got %b exp 1", b_ld_ready); n_fail++; end
      n_checks++;
      a_rst = 1'b0; b_rst = 1'b0;
   endtask

   task automatic test_basic_fetch();
      logic [31:0] exp_d [3] = '{32'h002180B3, 32'h00418133, 32'h006201B3};
      for (int i = 0; i < 3; i++) push_a(exp_d[i]);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k > 0) begin
            if (a_rvalid !== 1'b1) begin $display("FAIL basic_rvalid%0d: got %b exp 1", k, a_rvalid); n_fail++; end
            n_checks++;
            if (a_rdata !== exp_d[k-1]) begin $display("FAIL basic_rdata%0d: got %h exp %h", k, a_rdata, exp_d[k-1]); n_fail++; end
            n_checks++;
         end
         a_req  = (k < 3);
         a_addr = 32'h100 + 32'(4 * k);
         #1;
         if (k < 3) begin
            if (a_gnt !== 1'b1) begin $display("FAIL basic_gnt%0d: got %b exp 1", k, a_gnt); n_fail++; end
            n_checks++;
         end
      end
      @(negedge clk);
      if (a_rvalid !== 1'b0) begin $display("FAIL basic_idle_rvalid: got %b exp 0", a_rvalid); n_fail++; end
      n_checks++;
      if (a_rdata !== 32'h006201B3) begin $display("FAIL basic_hold_rdata: got %h exp 006201b3", a_rdata); n_fail++; end
      n_checks++;
      if (a_fetch_cnt !== 32'd3) begin $display("FAIL basic_fetch_cnt: got %0d exp 3", a_fetch_cnt); n_fail++; end
      n_checks++;
      if (a_underflow !== 1'b0) begin $display("FAIL basic_underflow: got %b exp 0", a_underflow); n_fail++; end
      n_checks++;
      if (a_last_addr !== 32'h108) begin $display("FAIL basic_last_addr: got %h exp 108", a_last_addr); n_fail++; end
      n_checks++;
   endtask

   task automatic test_underflow();
      @(negedge clk);
      a_req = 1'b1; a_addr = 32'h200;
      @(negedge clk);
      a_req = 1'b0;
      if (a_rvalid !== 1'b1) begin $display("FAIL uf_rvalid: got %b exp 1", a_rvalid); n_fail++; end
      n_checks++;
      if (a_rdata !== NOP) begin $display("FAIL uf_rdata: got %h exp %h", a_rdata, NOP); n_fail++; end
      n_checks++;
      if (a_underflow !== 1'b1) begin $display("FAIL uf_flag: got %b exp 1", a_underflow); n_fail++; end
      n_checks++;
      if (a_fetch_cnt !== 32'd4) begin $display("FAIL uf_fetch_cnt: got %0d exp 4", a_fetch_cnt); n_fail++; end
      n_checks++;
      repeat (3) @(negedge clk);
      if (a_underflow !== 1'b1) begin $display("FAIL uf_sticky: got %b exp 1", a_underflow); n_fail++; end
      n_checks++;
      if (a_rvalid !== 1'b0) begin $display("FAIL uf_idle_rvalid: got %b exp 0", a_rvalid); n_fail++; end
      n_checks++;
   endtask

   task automatic test_fifo_full();
      logic [31:0] e;
      reset_a();
      for (int i = 0; i < 16; i++) push_a(32'hA000_0000 + 32'(i));
      if (a_ld_ready !== 1'b0) begin $display("FAIL full_ready: got %b exp 0", a_ld_ready); n_fail++; end
      n_checks++;
      push_a(32'hDEADBEEF);
      if (a_ld_ready !== 1'b0) begin $display("FAIL full_ready_after_drop: got %b exp 0", a_ld_ready); n_fail++; end
      n_checks++;
      @(negedge clk);
      a_req = 1'b1;
      @(negedge clk);
      a_req = 1'b0;
      if (a_ld_ready !== 1'b1) begin $display("FAIL full_ready_after_pop: got %b exp 1", a_ld_ready); n_fail++; end
      n_checks++;
      if (a_rdata !== 32'hA000_0000) begin $display("FAIL full_first: got %h exp a0000000", a_rdata); n_fail++; end
      n_checks++;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = (i <= 15) ? (32'hA000_0000 + 32'(i)) : NOP;
            if (a_rvalid !== 1'b1 || a_rdata !== e) begin
               $display("FAIL full_drain%0d: got v=%b d=%h exp v=1 d=%h", i, a_rvalid, a_rdata, e); n_fail++;
            end
            n_checks++;
         end
         a_req = (i < 16);
      end
      if (a_underflow !== 1'b1) begin $display("FAIL full_drain_underflow: got %b exp 1", a_underflow); n_fail++; end
      n_checks++;
   endtask

   task automatic test_push_pop_same_cycle();
      reset_a();
      push_a(32'h11111111);
      @(negedge clk);
      a_req = 1'b1; a_ld_valid = 1'b1; a_ld_instr = 32'h22222222;
      @(negedge clk);
      a_req = 1'b0; a_ld_valid = 1'b0;
      if (a_rdata !== 32'h11111111) begin $display("FAIL pp_old_head: got %h exp 11111111", a_rdata); n_fail++; end
      n_checks++;
      @(negedge clk);
      a_req = 1'b1;
      @(negedge clk);
      a_req = 1'b0;
      if (a_rdata !== 32'h22222222 || a_underflow !== 1'b0) begin
         $display("FAIL pp_new_head: got d=%h uf=%b exp d=22222222 uf=0", a_rdata, a_underflow); n_fail++;
      end
      n_checks++;
      @(negedge clk);
      a_req = 1'b1;
      @(negedge clk);
      a_req = 1'b0;
      if (a_rdata !== NOP || a_underflow !== 1'b1) begin
         $display("FAIL pp_occupancy: got d=%h uf=%b exp d=%h uf=1", a_rdata, a_underflow, NOP); n_fail++;
      end
      n_checks++;
      // push into an empty FIFO is invisible to a pop in the same cycle
      reset_a();
      @(negedge clk);
      a_req = 1'b1; a_ld_valid = 1'b1; a_ld_instr = 32'h33333333;
      @(negedge clk);
      a_req = 1'b0; a_ld_valid = 1'b0;
      if (a_rdata !== NOP || a_underflow !== 1'b1) begin
         $display("FAIL pe_pop_sees_empty: got d=%h uf=%b exp d=%h uf=1", a_rdata, a_underflow, NOP); n_fail++;
      end
      n_checks++;
      @(negedge clk);
      a_req = 1'b1;
      @(negedge clk);
      a_req = 1'b0;
      if (a_rdata !== 32'h33333333) begin $display("FAIL pe_pushed_entry: got %h exp 33333333", a_rdata); n_fail++; end
      n_checks++;
   endtask

   task automatic test_back_to_back_lat3();
      logic [5:0]  pat = 6'b011011;
      logic [31:0] exp_d [6];
      int          idx = 0;
      reset_b();
      for (int i = 0; i < 6; i++) begin
         exp_d[i] = 32'hB000_0000 + 32'(i);
         push_b(exp_d[i]);
      end
      for (int cyc = 0; cyc < 14; cyc++) begin
         @(negedge clk);
         if (b_rvalid === 1'b1) begin
            if (idx >= 4) begin
               $display("FAIL b2b_extra_beat: got beat %0d exp at most 4", idx + 1); n_fail++;
               n_checks++;
            end else begin
               if (b_rdata !== exp_d[idx]) begin $display("FAIL b2b_rdata%0d: got %h exp %h", idx, b_rdata, exp_d[idx]); n_fail++; end
               n_checks++;
            end
            idx++;
         end
         b_req  = (cyc < 6);
         b_addr = 32'h400 + 32'(4 * cyc);
         #1;
         if (cyc < 6) begin
            if (b_gnt !== pat[cyc]) begin $display("FAIL b2b_gnt%0d: got %b exp %b", cyc, b_gnt, pat[cyc]); n_fail++; end
            n_checks++;
         end
      end
      if (idx != 4) begin $display("FAIL b2b_beats: got %0d exp 4", idx); n_fail++; end
      n_checks++;
      if (b_fetch_cnt !== 32'd4) begin $display("FAIL b2b_fetch_cnt: got %0d exp 4", b_fetch_cnt); n_fail++; end
      n_checks++;
      if (b_last_addr !== 32'h410) begin $display("FAIL b2b_last_addr: got %h exp 410", b_last_addr); n_fail++; end
      n_checks++;
   endtask

   task automatic test_reset_midflight();
      bit found = 1'b0;
      push_b(32'hC0000001);
      push_b(32'hC0000002);
      @(negedge clk);
      b_req = 1'b1;
      @(negedge clk);
      b_req = 1'b1;
      @(negedge clk);
      b_req = 1'b0;
      #1 b_rst = 1'b1;
      #1;
      if (b_rvalid !== 1'b0) begin $display("FAIL mid_rst_rvalid: got %b exp 0", b_rvalid); n_fail++; end
      n_checks++;
      if (b_fetch_cnt !== 32'd0) begin $display("FAIL mid_rst_fetch_cnt: got %0d exp 0", b_fetch_cnt); n_fail++; end
      n_checks++;
      @(negedge clk);
      b_rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (b_rvalid !== 1'b0) begin $display("FAIL mid_stray_beat%0d: got %b exp 0", i, b_rvalid); n_fail++; end
         n_checks++;
      end
      if (b_fetch_cnt !== 32'd0 || b_underflow !== 1'b0) begin
         $display("FAIL mid_after_release: got cnt=%0d uf=%b exp cnt=0 uf=0", b_fetch_cnt, b_underflow); n_fail++;
      end
      n_checks++;
      @(negedge clk);
      b_req = 1'b1;
      @(negedge clk);
      b_req = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         @(negedge clk);
         if (b_rvalid === 1'b1) found = 1'b1;
      end
      if (!found) begin $display("FAIL mid_new_beat: got no rvalid exp one within 6 cycles"); n_fail++; end
      n_checks++;
      if (b_rdata !== NOP) begin $display("FAIL mid_fifo_empty: got %h exp %h", b_rdata, NOP); n_fail++; end
      n_checks++;
      if (b_fetch_cnt !== 32'd1) begin $display("FAIL mid_fetch_cnt: got %0d exp 1", b_fetch_cnt); n_fail++; end
      n_checks++;
   endtask

   initial begin
      a_rst = 1'b1; a_req = 1'b0; a_addr = '0; a_ld_valid = 1'b0; a_ld_instr = '0;
      b_rst = 1'b1; b_req = 1'b0; b_addr = '0; b_ld_valid = 1'b0; b_ld_instr = '0;
      test_reset();
      test_basic_fetch();
      test_underflow();
      test_fifo_full();
      test_push_pop_same_cycle();
      test_back_to_back_lat3();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule
